// File: rtl/clock_pkg.sv
// Shared types and constant helpers for the time/alarm setter: FSM states,
// cycle-count conversions and the modular field step used by the edit datapath.
package clock_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_TIME,
      S_EDIT_TIME,
      S_LOAD_ALARM,
      S_EDIT_ALARM,
      S_COMMIT
   } state_e;

   // 64-bit intermediate keeps large clock rates from overflowing before the divide.
   function automatic int unsigned ms_cycles(input int unsigned clk_hz, input int unsigned ms);
      return 32'((64'(clk_hz) * 64'(ms)) / 64'd1000);
   endfunction

   function automatic int unsigned s_cycles(input int unsigned clk_hz, input int unsigned s);
      return clk_hz * s;
   endfunction

   // Step val by +/-1 or +/-10 modulo modulus; opposing requests cancel.
   function automatic int unsigned step_mod(input int unsigned val, input int unsigned modulus,
                                            input logic inc, input logic dec, input logic tens);
      int unsigned step;
      step = (tens ? 32'd10 : 32'd1) % modulus;
      if (inc && !dec) return (val + step >= modulus) ? val + step - modulus : val + step;
      if (dec && !inc) return (val >= step) ? val - step : val + modulus - step;
      return val;
   endfunction

endpackage

// File: rtl/btn_event.sv
// Active-low button conditioner: 2-flop sync, falling-edge event, and, when
// AUTO_REPEAT_EN is defined, hold-to-repeat after DLY_CYC then every RPT_CYC.
module btn_event #(
   parameter int unsigned DLY_CYC = 1,
   parameter int unsigned RPT_CYC = 1,
   parameter bit          REPEAT  = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_n_i,
   output logic evt_c_o
);

`ifdef AUTO_REPEAT_EN
   localparam bit REP_ON = REPEAT && (DLY_CYC != 0) && (RPT_CYC != 0);
`else
   localparam bit REP_ON = 1'b0 && REPEAT && (DLY_CYC != 0) && (RPT_CYC != 0);
`endif

   logic sync1_q, sync2_q, prev_q;
   logic warm1_q, warm2_q, armed_q;
   logic fall_c, rep_c;

   // Arm only after a real released level has been seen, so a button held
   // through reset produces nothing until it is let go.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         warm1_q <= 1'b0;
         warm2_q <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         sync1_q <= btn_n_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         warm1_q <= 1'b1;
         warm2_q <= warm1_q;
         armed_q <= armed_q | (warm2_q & sync2_q);
      end
   end

   assign fall_c  = armed_q & prev_q & ~sync2_q;
   assign evt_c_o = fall_c | rep_c;

   if (REP_ON) begin : g_repeat
      localparam int unsigned CW = $clog2(((DLY_CYC > RPT_CYC) ? DLY_CYC : RPT_CYC) + 1);
      logic [CW-1:0] cnt_q;
      logic          held_q, first_q;

      assign rep_c = held_q & ~sync2_q & (cnt_q == (first_q ? CW'(DLY_CYC) : CW'(RPT_CYC)));

      // cnt_q holds cycles since the last emitted event while the button stays down.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            cnt_q   <= '0;
            held_q  <= 1'b0;
            first_q <= 1'b0;
         end else if (fall_c) begin
            cnt_q   <= CW'(1);
            held_q  <= 1'b1;
            first_q <= 1'b1;
         end else if (sync2_q) begin
            held_q  <= 1'b0;
         end else if (held_q) begin
            if (rep_c) begin
               cnt_q   <= CW'(1);
               first_q <= 1'b0;
            end else begin
               cnt_q   <= cnt_q + CW'(1);
            end
         end
      end
   end else begin : g_no_repeat
      assign rep_c = 1'b0;
   end

endmodule

// File: rtl/time_alarm_setter.sv
// Clock time / alarm editor with per-button event conditioning, idle timeout
// and N_ALARMS stored alarms. Define AUTO_REPEAT_EN for hold-to-repeat buttons.
module time_alarm_setter
   import clock_pkg::*;
#(
   parameter int unsigned CLK_HZ        = 50_000_000,
   parameter int unsigned MAX_MINUTES   = 60,
   parameter int unsigned MAX_HOURS     = 24,
   parameter int unsigned N_ALARMS      = 2,
   parameter int unsigned TIMEOUT_S     = 30,
   parameter int unsigned REPEAT_DLY_MS = 500,
   parameter int unsigned REPEAT_MS     = 100,
   localparam int unsigned MW = $clog2(MAX_MINUTES),
   localparam int unsigned HW = $clog2(MAX_HOURS),
   localparam int unsigned AW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [MW-1:0]          cur_minutes,
   input  logic [HW-1:0]          cur_hours,
   input  logic                   time_mode_sw,
   input  logic                   alarm_mode_sw,
   input  logic [AW-1:0]          alarm_sel,
   input  logic                   min_tens_sw,
   input  logic                   hour_tens_sw,
   input  logic                   inc_min_n,
   input  logic                   dec_min_n,
   input  logic                   inc_hour_n,
   input  logic                   dec_hour_n,
   input  logic                   commit_n,
   output logic [MW-1:0]          edit_minutes,
   output logic [HW-1:0]          edit_hours,
   output logic                   editing,
   output logic                   set_time,
   output logic                   set_alarm,
   output logic [N_ALARMS*MW-1:0] alarm_minutes,
   output logic [N_ALARMS*HW-1:0] alarm_hours,
   output logic [N_ALARMS-1:0]    alarm_valid,
   output logic                   timeout
);

   localparam int unsigned TO_CYC  = s_cycles(CLK_HZ, TIMEOUT_S);
   localparam int unsigned TW      = $clog2(TO_CYC + 1);
   localparam int unsigned DLY_CYC = ms_cycles(CLK_HZ, REPEAT_DLY_MS);
   localparam int unsigned RPT_CYC = ms_cycles(CLK_HZ, REPEAT_MS);

   logic inc_min_e, dec_min_e, inc_hour_e, dec_hour_e, commit_e, any_evt_c;

   btn_event #(.DLY_CYC(DLY_CYC), .RPT_CYC(RPT_CYC), .REPEAT(1'b1)) u_inc_min (
      .clk(clk), .rst(rst), .btn_n_i(inc_min_n), .evt_c_o(inc_min_e));
   btn_event #(.DLY_CYC(DLY_CYC), .RPT_CYC(RPT_CYC), .REPEAT(1'b1)) u_dec_min (
      .clk(clk), .rst(rst), .btn_n_i(dec_min_n), .evt_c_o(dec_min_e));
   btn_event #(.DLY_CYC(DLY_CYC), .RPT_CYC(RPT_CYC), .REPEAT(1'b1)) u_inc_hour (
      .clk(clk), .rst(rst), .btn_n_i(inc_hour_n), .evt_c_o(inc_hour_e));
   btn_event #(.DLY_CYC(DLY_CYC), .RPT_CYC(RPT_CYC), .REPEAT(1'b1)) u_dec_hour (
      .clk(clk), .rst(rst), .btn_n_i(dec_hour_n), .evt_c_o(dec_hour_e));
   btn_event #(.DLY_CYC(DLY_CYC), .RPT_CYC(RPT_CYC), .REPEAT(1'b0)) u_commit (
      .clk(clk), .rst(rst), .btn_n_i(commit_n), .evt_c_o(commit_e));

   state_e                 state_q;
   logic [MW-1:0]          edit_min_q, edit_min_d;
   logic [HW-1:0]          edit_hour_q, edit_hour_d;
   logic [AW-1:0]          sel_q;
   logic                   is_alarm_q, editing_q;
   logic [TW-1:0]          tmr_q;
   logic                   set_time_q, set_alarm_q, timeout_q;
   logic [N_ALARMS*MW-1:0] alarm_min_q;
   logic [N_ALARMS*HW-1:0] alarm_hour_q;
   logic [N_ALARMS-1:0]    valid_q;

   assign any_evt_c   = inc_min_e | dec_min_e | inc_hour_e | dec_hour_e | commit_e;
   assign edit_min_d  = MW'(step_mod(32'(edit_min_q), MAX_MINUTES, inc_min_e, dec_min_e, min_tens_sw));
   assign edit_hour_d = HW'(step_mod(32'(edit_hour_q), MAX_HOURS, inc_hour_e, dec_hour_e, hour_tens_sw));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         edit_min_q   <= '0;
         edit_hour_q  <= '0;
         sel_q        <= '0;
         is_alarm_q   <= 1'b0;
         editing_q    <= 1'b0;
         tmr_q        <= '0;
         set_time_q   <= 1'b0;
         set_alarm_q  <= 1'b0;
         timeout_q    <= 1'b0;
         alarm_min_q  <= '0;
         alarm_hour_q <= '0;
         valid_q      <= '0;
      end else begin
         set_time_q  <= 1'b0;
         set_alarm_q <= 1'b0;
         timeout_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (time_mode_sw)       state_q <= S_LOAD_TIME;
               else if (alarm_mode_sw) state_q <= S_LOAD_ALARM;
            end
            S_LOAD_TIME: begin
               edit_min_q  <= cur_minutes;
               edit_hour_q <= cur_hours;
               is_alarm_q  <= 1'b0;
               editing_q   <= 1'b1;
               tmr_q       <= '0;
               state_q     <= S_EDIT_TIME;
            end
            S_LOAD_ALARM: begin
               sel_q       <= alarm_sel;
               edit_min_q  <= '0;
               edit_hour_q <= '0;
               if (32'(alarm_sel) < N_ALARMS) begin
                  edit_min_q  <= alarm_min_q[32'(alarm_sel)*MW +: MW];
                  edit_hour_q <= alarm_hour_q[32'(alarm_sel)*HW +: HW];
               end
               is_alarm_q  <= 1'b1;
               editing_q   <= 1'b1;
               tmr_q       <= '0;
               state_q     <= S_EDIT_ALARM;
            end
            S_EDIT_TIME, S_EDIT_ALARM: begin
               // Switch release aborts first, then commit, then stepping, then idle timeout.
               if (is_alarm_q ? !alarm_mode_sw : !time_mode_sw) begin
                  editing_q <= 1'b0;
                  state_q   <= S_IDLE;
               end else if (commit_e) begin
                  editing_q <= 1'b0;
                  state_q   <= S_COMMIT;
               end else if (any_evt_c) begin
                  edit_min_q  <= edit_min_d;
                  edit_hour_q <= edit_hour_d;
                  tmr_q       <= '0;
               end else if (tmr_q == TW'(TO_CYC - 1)) begin
                  editing_q <= 1'b0;
                  timeout_q <= 1'b1;
                  state_q   <= S_IDLE;
               end else begin
                  tmr_q <= tmr_q + TW'(1);
               end
            end
            S_COMMIT: begin
               state_q <= S_IDLE;
               if (is_alarm_q) begin
                  set_alarm_q <= 1'b1;
                  if (32'(sel_q) < N_ALARMS) begin
                     alarm_min_q[32'(sel_q)*MW +: MW]  <= edit_min_q;
                     alarm_hour_q[32'(sel_q)*HW +: HW] <= edit_hour_q;
                     valid_q[sel_q]                    <= 1'b1;
                  end
               end else begin
                  set_time_q <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign edit_minutes  = edit_min_q;
   assign edit_hours    = edit_hour_q;
   assign editing       = editing_q;
   assign set_time      = set_time_q;
   assign set_alarm     = set_alarm_q;
   assign timeout       = timeout_q;
   assign alarm_minutes = alarm_min_q;
   assign alarm_hours   = alarm_hour_q;
   assign alarm_valid   = valid_q;

endmodule

// File: doc/time_alarm_setter.md
TIME_ALARM_SETTER -- requirements
Module: time_alarm_setter

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, clock frequency used for all timing.
REQ-002 SHALL have parameter MAX_MINUTES, default 60, minute modulus.
REQ-003 SHALL have parameter MAX_HOURS, default 24, hour modulus.
REQ-004 SHALL have parameter N_ALARMS, default 2, number of stored alarms (>=1).
REQ-005 SHALL have parameter TIMEOUT_S, default 30, idle seconds before edit abort.
REQ-006 SHALL have parameter REPEAT_DLY_MS, default 500, hold time before first auto-repeat step.
REQ-007 SHALL have parameter REPEAT_MS, default 100, interval between auto-repeat steps.
REQ-008 SHALL have port list (MW = $clog2(MAX_MINUTES), HW = $clog2(MAX_HOURS), AW = max(1,$clog2(N_ALARMS))):
- clk  in  1  clock
- rst  in  1  reset: asynchronous, active-low
- cur_minutes  in  MW  running clock minutes
- cur_hours  in  HW  running clock hours
- time_mode_sw  in  1  1 = edit current time
- alarm_mode_sw  in  1  1 = edit alarm selected by alarm_sel
- alarm_sel  in  AW  alarm index
- min_tens_sw  in  1  0 = minute units step, 1 = minute tens step
- hour_tens_sw  in  1  same for hours
- inc_min_n, dec_min_n, inc_hour_n, dec_hour_n  in  1 each  asynchronous, active-low buttons
- commit_n  in  1  asynchronous, active-low save button
- edit_minutes  out  MW  working value for display
- edit_hours  out  HW  working value for display
- editing  out  1  high in either EDIT state
- set_time  out  1  one-cycle pulse; edit_* holds committed time
- set_alarm  out  1  one-cycle pulse on alarm commit
- alarm_minutes  out  N_ALARMS*MW  stored alarms, alarm k at [k*MW +: MW]
- alarm_hours  out  N_ALARMS*HW  stored alarms, same packing
- alarm_valid  out  N_ALARMS  alarm k has been committed
- timeout  out  1  one-cycle pulse on idle abort

Function
REQ-009 SHALL implement the FSM IDLE, LOAD_TIME, EDIT_TIME, LOAD_ALARM, EDIT_ALARM, COMMIT.
REQ-010 From IDLE, SHALL go to LOAD_TIME when time_mode_sw=1 (priority over alarm_mode_sw), else to LOAD_ALARM when alarm_mode_sw=1.
REQ-011 LOAD_TIME SHALL copy cur_* into edit_* in one cycle and then enter EDIT_TIME; LOAD_ALARM SHALL latch alarm_sel and copy the stored alarm into edit_* in one cycle and then enter EDIT_ALARM.
REQ-012 In EDIT_*, a button event SHALL step the field by ±1 (units) or ±10 (tens) modulo MAX: 55+10->5 min, 3-10->53 min, 23+10->9 h, 3-10->17 h.
REQ-013 A minute event and an hour event in the same cycle SHALL both apply; inc and dec on the same field in the same cycle SHALL leave it unchanged.
REQ-014 A commit event in EDIT_* SHALL enter COMMIT. COMMIT SHALL pulse set_time (time) or set_alarm (alarm) and write the stored alarm plus alarm_valid[idx]=1, then return to IDLE.
REQ-015 Deasserting the active mode switch in EDIT_* SHALL return to IDLE without commit and without a pulse.
REQ-016 After TIMEOUT_S*CLK_HZ cycles in EDIT_* with no button or commit event, the FSM SHALL return to IDLE and pulse timeout. Any event SHALL reset the timer.
REQ-017 Button latency: an input falling edge SHALL update edit_* on the 3rd rising clk edge (2-flop sync + edge detect).
REQ-018 alarm_sel changes during EDIT_ALARM SHALL be ignored; the latched index SHALL apply.
REQ-019 editing SHALL be high exactly in EDIT_TIME/EDIT_ALARM.

Reset
REQ-020 rst=0 SHALL force IDLE; all outputs, edit_*, stored alarms and alarm_valid SHALL be 0; sync flops SHALL be set to 1 (released). A reset mid-edit SHALL discard the edit with no pulse.
REQ-021 After release, a button already held low SHALL not generate an event.

Configuration
REQ-022 With AUTO_REPEAT_EN defined, a held inc/dec button SHALL emit one event at press, one after REPEAT_DLY_MS, then one every REPEAT_MS until release. Without it, each press SHALL emit exactly one event, and the repeat counters SHALL not be synthesised.

Structure
REQ-023 Package clock_pkg SHALL hold the FSM state enum, the ms/s cycle-count constant functions and the step/modulo helper function.
REQ-024 Sub-module btn_event (sync, falling-edge detect, optional repeat) SHALL be instantiated once per button (5x; commit never repeats).

Verification
REQ-025 Time edit: cur=12:34, time_mode_sw=1, inc_min x2, hour_tens_sw=1 + inc_hour, commit -> set_time pulse, edit=22:36.
REQ-026 Wrap: minute dec at 00 with units step -> 59; hour inc tens at 23 -> 09.
REQ-027 Alarm: N_ALARMS=2, alarm_sel=1, set 07:15, commit -> set_alarm pulse, alarm 1 = 07:15, alarm_valid=2'b10, alarm 0 unchanged.
REQ-028 Timeout: CLK_HZ=1000, TIMEOUT_S=1, no activity for 1000 cycles -> timeout pulse, IDLE, no set pulses.
REQ-029 Simultaneous: inc_min and dec_min asserted together -> minutes unchanged. inc_min and inc_hour together -> both increment.
REQ-030 AUTO_REPEAT_EN: CLK_HZ=1000, hold inc_min 800 cycles -> exactly 4 increments (at 0, 500, 600, 700 ms); macro undefined -> 1 increment.
